// File: rtl/prog_sequencer.sv
// Run controller for the fetch-stage program counter: sequences the benchmark
// programs, loads each base address, and reports completion by halt or timeout.
module prog_sequencer #(
    parameter int          PC_W       = 11,
    parameter int          NUM_PROGS  = 3,
    parameter int          PROG0_BASE = 0,
    parameter int          PROG1_BASE = 256,
    parameter int          PROG2_BASE = 512,
    parameter logic [15:0] MAX_CYCLES = 16'd60000
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_Start,
    input  logic            i_Halt,
    output logic            o_PcHold,
    output logic            o_PcLoad,
    output logic [PC_W-1:0] o_PcLoadAddr,
    output logic [1:0]      o_ProgIdx,
    output logic            o_Done,
    output logic            o_TimedOut,
    output logic [15:0]     o_CycleCount
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [PC_W-1:0] BASE0    = PC_W'(PROG0_BASE);
    localparam logic [PC_W-1:0] BASE1    = PC_W'(PROG1_BASE);
    localparam logic [PC_W-1:0] BASE2    = PC_W'(PROG2_BASE);
    localparam logic [1:0]      LAST_IDX = 2'(NUM_PROGS - 1);

    state_t      r_State;
    state_t      w_NextState;
    logic [1:0]  r_ProgIdx;
    logic [15:0] r_CycleCount;
    logic        r_TimedOut;
    logic        w_Timeout;

    // The current RUN cycle is the last one allowed before forced completion.
    assign w_Timeout = (r_CycleCount == (MAX_CYCLES - 16'd1));

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            IDLE:    if (i_Start) w_NextState = ARMED;
            ARMED:   if (!i_Start) w_NextState = LOAD;
            LOAD:    w_NextState = RUN;
            RUN: begin
                if (i_Halt || w_Timeout) begin
                    w_NextState = DONE;
                end else if (i_Start) begin
                    w_NextState = ARMED;
                end
            end
            DONE:    if (i_Start) w_NextState = ARMED;
            default: w_NextState = IDLE;
        endcase
    end

    // Halt has priority over the timeout, so TimedOut is only set without Halt.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_ProgIdx    <= 2'd0;
            r_CycleCount <= 16'd0;
            r_TimedOut   <= 1'b0;
        end else begin
            case (r_State)
                ARMED: begin
                    if (!i_Start) begin
                        r_CycleCount <= 16'd0;
                        r_TimedOut   <= 1'b0;
                    end
                end
                RUN: begin
                    r_CycleCount <= r_CycleCount + 16'd1;
                    if (!i_Halt && w_Timeout) begin
                        r_TimedOut <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_Start) begin
                        r_ProgIdx <= (r_ProgIdx == LAST_IDX) ? 2'd0 : r_ProgIdx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_PcHold = 1'b0;
        o_PcLoad = 1'b0;
        o_Done   = 1'b0;
        case (r_State)
            IDLE:    o_PcHold = 1'b1;
            ARMED:   o_PcHold = 1'b1;
            LOAD:    o_PcLoad = 1'b1;
            RUN:     ;
            DONE: begin
                o_PcHold = 1'b1;
                o_Done   = 1'b1;
            end
            default: o_PcHold = 1'b1;
        endcase
    end

    always_comb begin
        case (r_ProgIdx)
            2'd1:    o_PcLoadAddr = BASE1;
            2'd2:    o_PcLoadAddr = BASE2;
            default: o_PcLoadAddr = BASE0;
        endcase
    end

    assign o_ProgIdx    = r_ProgIdx;
    assign o_TimedOut   = r_TimedOut;
    assign o_CycleCount = r_CycleCount;

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Top-level run controller for the program counter in the fetch stage. It sequences the three benchmark programs back to back.
- Handles the Start handshake and loads each program's base address into the PC.
- Holds the PC when no program is running, detects program completion (halt instruction or timeout) and reports Done to the bench.
- Drives the PC hold/load inputs of the next-revision fetch unit. It does not compute branch targets.

Parameters:
- PC_W, 11, program counter width.
- NUM_PROGS, 3, number of programs; ProgIdx wraps from NUM_PROGS-1 to 0.
- PROG0_BASE, 0, base address of program 0.
- PROG1_BASE, 256, base address of program 1.
- PROG2_BASE, 512, base address of program 2.
- MAX_CYCLES, 16'd60000, run-cycle limit before forced completion. Legal range 1..65535.

Ports:
- Clk  in  1  system clock, all state changes on posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  level from bench; a program begins after Start is released.
- Halt  in  1  decoder flag: the instruction at the current PC is a halt.
- PcHold  out  1  fetch unit must keep PC unchanged.
- PcLoad  out  1  fetch unit loads PcLoadAddr at the next edge; overrides hold, branch and increment.
- PcLoadAddr  out  PC_W  base address of the selected program.
- ProgIdx  out  2  index of the current or last-finished program.
- Done  out  1  program finished; held until next Start.
- TimedOut  out  1  last completion was caused by MAX_CYCLES, not Halt.
- CycleCount  out  16  RUN cycles of the current or last program.

Behaviour:
- Reset is synchronous, active-high, clock Clk.
- Reset values: state IDLE, PcHold=1, PcLoad=0, PcLoadAddr=PROG0_BASE, ProgIdx=0, Done=0, TimedOut=0, CycleCount=0.
- Reset asserted in any state, including mid-RUN, returns to these values at the next edge.
- Outputs are registered or decoded from registered state (Moore). There is no combinational path from any input to any output.
- PcLoadAddr = base selected by ProgIdx at all times.
- FSM states: IDLE, ARMED, LOAD, RUN, DONE.
- IDLE:
  - PcHold=1.
  - Start=1 -> ARMED.
- ARMED:
  - PcHold=1, Done=0.
  - Stays while Start=1; Start=0 -> LOAD.
- LOAD (exactly one cycle):
  - PcLoad=1, PcHold=0.
  - CycleCount cleared to 0, TimedOut cleared.
  - -> RUN.
  - PC equals the base at the first RUN cycle.
- RUN:
  - PcHold=0, PcLoad=0.
  - CycleCount increments every RUN cycle, including the halt cycle.
  - Halt=1 -> DONE with TimedOut=0.
  - Else if CycleCount == MAX_CYCLES-1 -> DONE with TimedOut=1; CycleCount ends at MAX_CYCLES.
  - Else if Start=1 -> ARMED (abort). ProgIdx is unchanged, so the same program reloads; CycleCount is frozen.
  - Halt and Start in the same cycle: Halt wins; Start is then seen in DONE.
  - Halt and timeout in the same cycle: Halt wins, TimedOut=0.
- DONE:
  - Done=1, PcHold=1; ProgIdx still names the finished program; CycleCount frozen.
  - Start=1 -> ARMED. On that transition ProgIdx increments with wrap, and Done drops in the ARMED cycle.
- Latency:
  - Start sampled 0 in ARMED at edge k -> PcLoad high in cycle k..k+1 -> PC=base after edge k+1.
  - Halt sampled at edge k -> Done=1 after edge k.
- PcHold and PcLoad are never both 1.
- Halt is ignored outside RUN.

Test Plan:
1. Reset, then Start=1 for 3 cycles, then 0 -> ARMED for 3 cycles, one LOAD cycle with PcLoad=1 and PcLoadAddr=0, then RUN with PcHold=0 and CycleCount counting 1, 2, 3...
2. In RUN, Halt=1 on the 10th RUN cycle -> Done=1, CycleCount=10, ProgIdx=0, TimedOut=0. Then Start pulse -> ProgIdx=1, Done=0, LOAD with PcLoadAddr=256.
3. Complete programs 1 and 2 via Halt, then Start -> ProgIdx wraps to 0, PcLoadAddr=0.
4. MAX_CYCLES=20, no Halt -> DONE after the 20th RUN cycle, TimedOut=1, CycleCount=20. The next program's LOAD clears TimedOut.
5. Start=1 during RUN of program 1 -> ARMED, PcHold=1, ProgIdx=1. On release, reload with PcLoadAddr=256 and CycleCount restarting at 0. Halt and Start together in RUN -> DONE first, then ARMED the next cycle with ProgIdx+1.
6. Reset asserted mid-RUN of program 2 -> next cycle IDLE, ProgIdx=0, Done=0, PcHold=1, CycleCount=0. Halt pulsed in IDLE/DONE -> no state change.
